// File: rtl/kilit_kontrolcu_if.sv
// rtl/kilit_kontrolcu_if.sv - dial/confirm inputs, checker link and status outputs of the lock front end
interface kilit_kontrolcu_if;
    logic       sag_darbe;
    logic       sol_darbe;
    logic       onayla;
    logic       programla;
    logic [5:0] yeni_sifre;
    logic       kilit_acik;
    logic [2:0] sag_adim;
    logic [1:0] sol_adim;
    logic [5:0] kilit_sifre;
    logic       acik;
    logic       hata;
    logic       kilitli;
    logic       sifre_yazildi;
    logic [2:0] durum;

    modport slave (
        input  sag_darbe, sol_darbe, onayla, programla, yeni_sifre, kilit_acik,
        output sag_adim, sol_adim, kilit_sifre, acik, hata, kilitli, sifre_yazildi, durum
    );

    modport master (
        output sag_darbe, sol_darbe, onayla, programla, yeni_sifre, kilit_acik,
        input  sag_adim, sol_adim, kilit_sifre, acik, hata, kilitli, sifre_yazildi, durum
    );
endinterface

// File: rtl/kilit_kontrolcu.sv
// rtl/kilit_kontrolcu.sv - lock front-end FSM (dial counting, open time, password write); lockout under KILIT_KONTROLCU_KILITLENME_EN
module kilit_kontrolcu #(
    parameter logic [5:0] VARSAYILAN_SIFRE = 6'd0,
    parameter int         ACIK_SURE        = 16,
    parameter int         ZAMAN_ASIMI      = 1000
`ifdef KILIT_KONTROLCU_KILITLENME_EN
    ,
    parameter int         MAX_DENEME       = 3,
    parameter int         KILIT_SURE       = 5000
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    kilit_kontrolcu_if.slave  bus
);

    typedef enum logic [2:0] {
        BOSTA   = 3'd0,
        SAG     = 3'd1,
        SOL     = 3'd2,
        KONTROL = 3'd3,
        ACIK    = 3'd4,
        KILIT   = 3'd5
    } durum_t;

    durum_t      durum_q;
    logic [2:0]  sag_q;
    logic [1:0]  sol_q;
    logic [5:0]  sifre_q;
    logic        acik_q;
    logic        hata_q;
    logic        yazildi_q;
    logic        tasma;
    logic        hata_bayrak;
    logic [15:0] zaman;
    logic        basari;

`ifdef KILIT_KONTROLCU_KILITLENME_EN
    localparam int DW = $clog2(MAX_DENEME + 1);
    logic          kilitli_q;
    logic [DW-1:0] deneme;
`endif

    // kilit_acik is combinational on our registered outputs, so it is
    // already valid for the current counts during the KONTROL cycle.
    assign basari = bus.kilit_acik & ~tasma & ~hata_bayrak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            durum_q     <= BOSTA;
            sag_q       <= 3'd0;
            sol_q       <= 2'd0;
            sifre_q     <= VARSAYILAN_SIFRE;
            acik_q      <= 1'b0;
            hata_q      <= 1'b0;
            yazildi_q   <= 1'b0;
            tasma       <= 1'b0;
            hata_bayrak <= 1'b0;
            zaman       <= 16'd0;
`ifdef KILIT_KONTROLCU_KILITLENME_EN
            kilitli_q   <= 1'b0;
            deneme      <= '0;
`endif
        end else begin
            hata_q    <= 1'b0;
            yazildi_q <= 1'b0;
            case (durum_q)
                BOSTA: begin
                    if (bus.sag_darbe) begin
                        durum_q     <= SAG;
                        sag_q       <= 3'd1;
                        hata_bayrak <= bus.sol_darbe;
                        zaman       <= 16'd0;
                    end
                end
                SAG: begin
                    if (bus.onayla) begin
                        durum_q <= KONTROL;
                    end else if (bus.sag_darbe && bus.sol_darbe) begin
                        hata_bayrak <= 1'b1;
                        zaman       <= 16'd0;
                    end else if (bus.sol_darbe) begin
                        durum_q <= SOL;
                        sol_q   <= 2'd1;
                        zaman   <= 16'd0;
                    end else if (bus.sag_darbe) begin
                        if (sag_q == 3'd7) tasma <= 1'b1;
                        else               sag_q <= sag_q + 3'd1;
                        zaman <= 16'd0;
                    end else if (zaman == 16'(ZAMAN_ASIMI - 1)) begin
                        durum_q     <= BOSTA;
                        sag_q       <= 3'd0;
                        sol_q       <= 2'd0;
                        tasma       <= 1'b0;
                        hata_bayrak <= 1'b0;
                    end else begin
                        zaman <= zaman + 16'd1;
                    end
                end
                SOL: begin
                    if (bus.onayla) begin
                        durum_q <= KONTROL;
                    end else if (bus.sag_darbe || bus.sol_darbe) begin
                        zaman <= 16'd0;
                        // A right pulse after the left phase began is an order violation.
                        if (bus.sag_darbe) hata_bayrak <= 1'b1;
                        if (bus.sol_darbe) begin
                            if (sol_q == 2'd3) tasma <= 1'b1;
                            else               sol_q <= sol_q + 2'd1;
                        end
                    end else if (zaman == 16'(ZAMAN_ASIMI - 1)) begin
                        durum_q     <= BOSTA;
                        sag_q       <= 3'd0;
                        sol_q       <= 2'd0;
                        tasma       <= 1'b0;
                        hata_bayrak <= 1'b0;
                    end else begin
                        zaman <= zaman + 16'd1;
                    end
                end
                KONTROL: begin
                    sag_q       <= 3'd0;
                    sol_q       <= 2'd0;
                    tasma       <= 1'b0;
                    hata_bayrak <= 1'b0;
                    if (basari) begin
                        durum_q <= ACIK;
                        acik_q  <= 1'b1;
                        zaman   <= 16'd0;
`ifdef KILIT_KONTROLCU_KILITLENME_EN
                        deneme  <= '0;
`endif
                    end else begin
                        hata_q <= 1'b1;
`ifdef KILIT_KONTROLCU_KILITLENME_EN
                        deneme <= deneme + 1'b1;
                        if (int'(deneme) + 1 >= MAX_DENEME) begin
                            durum_q   <= KILIT;
                            kilitli_q <= 1'b1;
                            zaman     <= 16'd0;
                        end else begin
                            durum_q <= BOSTA;
                        end
`else
                        durum_q <= BOSTA;
`endif
                    end
                end
                ACIK: begin
                    if (bus.programla) begin
                        sifre_q   <= bus.yeni_sifre;
                        yazildi_q <= 1'b1;
                    end
                    if (bus.onayla || zaman == 16'(ACIK_SURE - 1)) begin
                        durum_q <= BOSTA;
                        acik_q  <= 1'b0;
                    end else begin
                        zaman <= zaman + 16'd1;
                    end
                end
`ifdef KILIT_KONTROLCU_KILITLENME_EN
                KILIT: begin
                    if (zaman == 16'(KILIT_SURE - 1)) begin
                        durum_q   <= BOSTA;
                        kilitli_q <= 1'b0;
                        deneme    <= '0;
                    end else begin
                        zaman <= zaman + 16'd1;
                    end
                end
`endif
                default: durum_q <= BOSTA;
            endcase
        end
    end

    assign bus.sag_adim      = sag_q;
    assign bus.sol_adim      = sol_q;
    assign bus.kilit_sifre   = sifre_q;
    assign bus.acik          = acik_q;
    assign bus.hata          = hata_q;
    assign bus.sifre_yazildi = yazildi_q;
    assign bus.durum         = durum_q;
`ifdef KILIT_KONTROLCU_KILITLENME_EN
    assign bus.kilitli       = kilitli_q;
`else
    assign bus.kilitli       = 1'b0;
`endif

endmodule

// File: tb/tb_kilit_kontrolcu.sv
// tb/tb_kilit_kontrolcu.sv - directed table and sequence bench for kilit_kontrolcu
module tb_kilit_kontrolcu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    kilit_kontrolcu_if bus();

    kilit_kontrolcu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference checker: right 3, left 2, password 0.
    assign bus.kilit_acik = (bus.sag_adim == 3'd3) && (bus.sol_adim == 2'd2) && (bus.kilit_sifre == 6'd0);

    typedef struct {
        logic       s;
        logic       l;
        logic       o;
        logic [2:0] es;
        logic [1:0] el;
        logic       ea;
        logic       eh;
        logic [2:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic l, input logic o, input logic [2:0] es,
                       input logic [1:0] el, input logic ea, input logic eh, input logic [2:0] ed);
        vec_t v;
        v = '{s, l, o, es, el, ea, eh, ed};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Dial entry ending with the onayla edge; caller is left at the KONTROL sample.
    task automatic giris(input int ns, input int nl);
        for (int i = 0; i < ns; i++) begin
            bus.sag_darbe = 1'b1; tick(); bus.sag_darbe = 1'b0;
        end
        for (int i = 0; i < nl; i++) begin
            bus.sol_darbe = 1'b1; tick(); bus.sol_darbe = 1'b0;
        end
        bus.onayla = 1'b1; tick(); bus.onayla = 1'b0;
    endtask

    initial begin
        int n;
        logic hata_gordu;

        bus.sag_darbe  = 1'b0;
        bus.sol_darbe  = 1'b0;
        bus.onayla     = 1'b0;
        bus.programla  = 1'b0;
        bus.yeni_sifre = 6'd0;

        // ignored inputs in BOSTA
        add(0,1,0, 3'd0,2'd0,0,0,3'd0);
        add(0,0,1, 3'd0,2'd0,0,0,3'd0);
        // wrong entry 2R 2L
        add(1,0,0, 3'd1,2'd0,0,0,3'd1);
        add(1,0,0, 3'd2,2'd0,0,0,3'd1);
        add(0,1,0, 3'd2,2'd1,0,0,3'd2);
        add(0,1,0, 3'd2,2'd2,0,0,3'd2);
        add(0,0,1, 3'd2,2'd2,0,0,3'd3);
        add(0,0,0, 3'd0,2'd0,0,1,3'd0);
        add(0,0,0, 3'd0,2'd0,0,0,3'd0);
        // order violation 3R 1L 1R 1L
        add(1,0,0, 3'd1,2'd0,0,0,3'd1);
        add(1,0,0, 3'd2,2'd0,0,0,3'd1);
        add(1,0,0, 3'd3,2'd0,0,0,3'd1);
        add(0,1,0, 3'd3,2'd1,0,0,3'd2);
        add(1,0,0, 3'd3,2'd1,0,0,3'd2);
        add(0,1,0, 3'd3,2'd2,0,0,3'd2);
        add(0,0,1, 3'd3,2'd2,0,0,3'd3);
        add(0,0,0, 3'd0,2'd0,0,1,3'd0);
        // correct entry, closed early by onayla
        add(1,0,0, 3'd1,2'd0,0,0,3'd1);
        add(1,0,0, 3'd2,2'd0,0,0,3'd1);
        add(1,0,0, 3'd3,2'd0,0,0,3'd1);
        add(0,1,0, 3'd3,2'd1,0,0,3'd2);
        add(0,1,0, 3'd3,2'd2,0,0,3'd2);
        add(0,0,1, 3'd3,2'd2,0,0,3'd3);
        add(0,0,0, 3'd0,2'd0,1,0,3'd4);
        add(1,1,0, 3'd0,2'd0,1,0,3'd4);
        add(0,0,1, 3'd0,2'd0,0,0,3'd0);
        // both pulses together in BOSTA, then a would-be correct entry
        add(1,1,0, 3'd1,2'd0,0,0,3'd1);
        add(1,0,0, 3'd2,2'd0,0,0,3'd1);
        add(1,0,0, 3'd3,2'd0,0,0,3'd1);
        add(0,1,0, 3'd3,2'd1,0,0,3'd2);
        add(0,1,0, 3'd3,2'd2,0,0,3'd2);
        add(0,0,1, 3'd3,2'd2,0,0,3'd3);
        add(0,0,0, 3'd0,2'd0,0,1,3'd0);

        // reset state
        tick(); tick();
        chk("reset_outs", {29'd0, bus.durum}, 32'd0);
        chk("reset_flags", {bus.acik, bus.hata, bus.kilitli, bus.sifre_yazildi, bus.sag_adim, bus.sol_adim}, 32'd0);
        chk("reset_sifre", bus.kilit_sifre, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            bus.sag_darbe = vecs[i].s;
            bus.sol_darbe = vecs[i].l;
            bus.onayla    = vecs[i].o;
            tick();
            bus.sag_darbe = 1'b0;
            bus.sol_darbe = 1'b0;
            bus.onayla    = 1'b0;
            chk($sformatf("vec%0d", i),
                {bus.sag_adim, bus.sol_adim, bus.acik, bus.hata, bus.durum},
                {vecs[i].es, vecs[i].el, vecs[i].ea, vecs[i].eh, vecs[i].ed});
        end

        // programla outside ACIK is ignored
        bus.programla = 1'b1; bus.yeni_sifre = 6'h15; tick(); bus.programla = 1'b0;
        chk("prog_bosta", {bus.sifre_yazildi, bus.kilit_sifre}, 32'd0);

        // correct entry: latency and 16-cycle open time
        giris(3, 2);
        chk("kontrol_latency", {bus.acik, bus.hata, bus.durum}, {2'b00, 3'd3});
        tick();
        n = 0;
        while (bus.acik && n < 40) begin
            n++;
            tick();
        end
        chk("acik_sure", n, 32'd16);
        chk("acik_bitti_durum", bus.durum, 32'd0);

        // right-count saturation
        for (int i = 0; i < 9; i++) begin
            bus.sag_darbe = 1'b1; tick(); bus.sag_darbe = 1'b0;
        end
        chk("sag_doyma", bus.sag_adim, 32'd7);
        bus.onayla = 1'b1; tick(); bus.onayla = 1'b0;
        tick();
        chk("doyma_hata", {bus.hata, bus.acik, bus.durum}, {2'b10, 3'd0});

        // entry timeout
        bus.sag_darbe = 1'b1; tick(); bus.sag_darbe = 1'b0;
        hata_gordu = 1'b0;
        for (int i = 0; i < 999; i++) begin
            tick();
            hata_gordu |= bus.hata;
        end
        chk("zaman_asimi_once", bus.durum, 32'd1);
        tick();
        hata_gordu |= bus.hata;
        chk("zaman_asimi_sonra", {bus.durum, bus.sag_adim}, 32'd0);
        chk("zaman_asimi_hatasiz", hata_gordu, 32'd0);

        // password write in ACIK, then async reset restores default
        giris(3, 2);
        tick();
        chk("prog_acik_giris", bus.acik, 32'd1);
        bus.programla = 1'b1; bus.yeni_sifre = 6'h2A; tick(); bus.programla = 1'b0;
        chk("sifre_yazildi", bus.sifre_yazildi, 32'd1);
        chk("sifre_deger", bus.kilit_sifre, 32'h2A);
        chk("prog_durum", bus.durum, 32'd4);
        tick();
        chk("sifre_yazildi_darbe", bus.sifre_yazildi, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", {bus.kilit_sifre, bus.acik, bus.durum}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // three consecutive failures
        for (int k = 0; k < 3; k++) begin
            giris(2, 2);
            tick();
            chk($sformatf("deneme%0d_hata", k), bus.hata, 32'd1);
`ifdef KILIT_KONTROLCU_KILITLENME_EN
            if (k == 2) chk("kilit_giris", {bus.kilitli, bus.durum}, {1'b1, 3'd5});
            else        chk($sformatf("deneme%0d_durum", k), {bus.kilitli, bus.durum}, 32'd0);
`else
            chk($sformatf("deneme%0d_durum", k), {bus.kilitli, bus.durum}, 32'd0);
`endif
        end

`ifdef KILIT_KONTROLCU_KILITLENME_EN
        n = 1;
        giris(3, 2);
        n += 6;
        tick();
        n++;
        chk("kilit_giris_yok", {bus.acik, bus.kilitli, bus.durum}, {2'b01, 3'd5});
        while (n < 6000) begin
            tick();
            if (!bus.kilitli) break;
            n++;
        end
        chk("kilit_sure", n, 32'd5000);
        chk("kilit_sonra_durum", bus.durum, 32'd0);
`endif

        giris(3, 2);
        tick();
        chk("son_acik", {bus.acik, bus.hata, bus.durum}, {2'b10, 3'd4});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kilit_kontrolcu.md
Name: kilit_kontrolcu

Overview:
- Sequential front end for the combinational lock checker. Counts right-turn and left-turn dial pulses into a step pair and holds the stored 6-bit password.
- Drives sag_adim/sol_adim/kilit_sifre into the checker, samples its kilit_acik result, and manages open time, failed attempts, lockout and password reprogramming.

Parameters:
- VARSAYILAN_SIFRE, 6'd0, kilit_sifre value after reset.
- ACIK_SURE, 16, cycles the lock stays open.
- ZAMAN_ASIMI, 1000, idle cycles allowed during entry before the entry is discarded.
- MAX_DENEME, 3, consecutive failures that trigger lockout.
- KILIT_SURE, 5000, lockout length in cycles.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sag_darbe  in  1  one-cycle pulse per right detent.
- sol_darbe  in  1  one-cycle pulse per left detent.
- onayla  in  1  confirm entry; in ACIK, close early.
- programla  in  1  write yeni_sifre (honoured in ACIK only).
- yeni_sifre  in  6  new password value.
- kilit_acik  in  1  checker result, combinational on the three outputs below.
- sag_adim  out  3  right step count to checker.
- sol_adim  out  2  left step count to checker.
- kilit_sifre  out  6  stored password to checker.
- acik  out  1  lock open.
- hata  out  1  one-cycle failure pulse.
- kilitli  out  1  lockout active.
- sifre_yazildi  out  1  one-cycle pulse when the password is written.
- durum  out  3  current FSM state encoding.

Behaviour:
- Reset (async, rst_n=0): state BOSTA, sag_adim=0, sol_adim=0, kilit_sifre=VARSAYILAN_SIFRE, all flags/counters 0, acik=hata=kilitli=sifre_yazildi=0.
- State encodings: BOSTA=0, SAG=1, SOL=2, KONTROL=3, ACIK=4, KILIT=5.
- All outputs are registered.
- Timer starts at 0 on every entry into SAG, SOL, ACIK and KILIT.
- BOSTA:
  - sag_darbe → SAG, sag_adim=1.
  - sol_darbe or onayla: ignored.
  - sag_darbe and sol_darbe in the same cycle → hata_bayrak=1, still enter SAG with sag_adim=1.
- SAG:
  - sag_darbe: sag_adim+1. A pulse while sag_adim=7 sets tasma and leaves sag_adim at 7.
  - sol_darbe → SOL, sol_adim=1.
  - Both pulses in the same cycle → hata_bayrak=1, no count change.
  - onayla → KONTROL.
- SOL:
  - sol_darbe: sol_adim+1, saturating at 3 with tasma set.
  - sag_darbe → hata_bayrak=1 (order violation), stay in SOL.
  - onayla → KONTROL.
- Timeout: in SAG/SOL, the timer resets on any pulse. Reaching ZAMAN_ASIMI → BOSTA with counts and flags cleared; no hata, no attempt counted.
- KONTROL (exactly one cycle, outputs stable):
  - basari = kilit_acik & ~tasma & ~hata_bayrak.
  - Success → ACIK, deneme=0.
  - Failure → hata=1 for one cycle, deneme+1. If deneme reaches MAX_DENEME → KILIT, else BOSTA.
  - On leaving KONTROL: sag_adim=sol_adim=0, tasma and hata_bayrak cleared.
- ACIK:
  - acik=1.
  - Timer reaches ACIK_SURE, or onayla → BOSTA.
  - programla → kilit_sifre=yeni_sifre, sifre_yazildi=1 for one cycle, stay in ACIK.
  - Dial pulses are ignored.
- KILIT:
  - kilitli=1, all inputs ignored.
  - After KILIT_SURE cycles → BOSTA, deneme=0.
- programla outside ACIK: ignored.
- Latency: onayla at cycle N → KONTROL at N+1 → acik or hata visible at N+2.
- rst_n low mid-operation: immediate return to reset values. The password reverts to VARSAYILAN_SIFRE.

Optional Feature:
- KILIT_KONTROLCU_KILITLENME_EN defined: deneme counter and KILIT state present as above.
- Undefined: no deneme counter, no KILIT state. Every failure returns to BOSTA, and kilitli is tied to 0.

Test Plan:
- Bench model: kilit_acik = (sag_adim==3 && sol_adim==2 && kilit_sifre==6'd0).
- Correct entry: 3 sag_darbe, 2 sol_darbe, onayla → hata=0, acik=1 two cycles after onayla, held 16 cycles, then durum=0.
- Wrong entry: 2 right, 2 left, onayla → one-cycle hata=1, durum=0, sag_adim=sol_adim=0.
- Order violation: 3 right, 1 left, 1 right, 1 left, onayla → hata=1 even though sag_adim=3, sol_adim=2.
- Lockout (macro defined): three wrong entries → kilitli=1 for 5000 cycles; a correct entry during lockout gives no acik; after lockout a correct entry opens.
- Programming and saturation:
  - In ACIK, programla with yeni_sifre=6'h2A → sifre_yazildi pulse, kilit_sifre=0x2A.
  - 9 right pulses → sag_adim=7, onayla gives hata.
  - Async reset restores kilit_sifre=0.
